// File: rtl/sprite_row_fetcher.sv
// Sprite row fetcher: during horizontal blanking, reads each player's sprite row
// for the next scanline from the shared sync ROM into shadow registers. The shadow
// registers are copied to the active row registers at line start, and the pixel
// path reads only the active registers.
//
// ROM handshake: RomReq acts as "valid" and RomGnt as "ready". A request is
// accepted in a cycle where both are high. While RomReq is high and not yet
// granted, RomAddr holds its value. RomData is captured exactly ROM_LAT cycles
// after the accepting cycle.
module sprite_row_fetcher #(
  parameter int          SPRITE_H     = 16,
  parameter int          ROM_LAT      = 1,
  parameter int          HBLANK_START = 640,
  parameter int          H_LAST       = 799,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_LAST       = 524,
  parameter logic [11:0] P1_BASE      = 12'd0,
  parameter logic [11:0] P2_BASE      = 12'd16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  P1Y,
  input  logic [9:0]  P2Y,
  output logic        RomReq,
  input  logic        RomGnt,
  output logic [11:0] RomAddr,
  input  logic [47:0] RomData,
  output logic [47:0] P1Row,
  output logic [47:0] P2Row,
  output logic        P1Valid,
  output logic        P2Valid,
  output logic        Overrun,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [9:0] HB_X     = 10'(HBLANK_START);
  localparam logic [9:0] LAST_X   = 10'(H_LAST);
  localparam logic [9:0] LAST_Y   = 10'(V_LAST);
  localparam logic [3:0] LAT_LAST = 4'(ROM_LAT - 1);

  state_t      state, state_n;
  logic [9:0]  prev_x;
  logic        trigger, commit;
  logic [9:0]  next_line;
  logic        hit1_q, hit2_q;
  logic [3:0]  off1_q, off2_q;
  logic [3:0]  wait_cnt;
  logic [47:0] sh1_row, sh2_row;
  logic        sh1_v, sh2_v;
  logic        rom_req;
  logic [11:0] rom_addr;

  // A row is needed only when the line is visible and lies inside the sprite.
  // The compare is done in 11 bits so that PnY+SPRITE_H cannot wrap.
  function automatic logic row_hit(input logic [9:0] nl, input logic [9:0] py);
    logic [10:0] n, y;
    n = {1'b0, nl};
    y = {1'b0, py};
    return (n < 11'(V_ACTIVE)) && (n >= y) && (n < y + 11'(SPRITE_H));
  endfunction

  assign trigger   = (DrawX == HB_X) && (prev_x != HB_X);
  assign commit    = (DrawX == 10'd0) && (prev_x == LAST_X);
  assign next_line = (DrawY == LAST_Y) ? 10'd0 : DrawY + 10'd1;

  // Remember the previous DrawX so that the trigger and commit events are single-cycle pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) prev_x <= '0;
    else       prev_x <= DrawX;
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and ROM request. A commit overrides everything and drops any pending request.
  always_comb begin
    state_n  = state;
    rom_req  = 1'b0;
    rom_addr = '0;
    case (state)
      IDLE:  if (trigger) state_n = REQ1;
      REQ1: begin
        if (!hit1_q) state_n = REQ2;
        else begin
          rom_req  = 1'b1;
          rom_addr = P1_BASE + {8'd0, off1_q};
          if (RomGnt) state_n = WAIT1;
        end
      end
      WAIT1: if (wait_cnt == LAT_LAST) state_n = REQ2;
      REQ2: begin
        if (!hit2_q) state_n = DONE;
        else begin
          rom_req  = 1'b1;
          rom_addr = P2_BASE + {8'd0, off2_q};
          if (RomGnt) state_n = WAIT2;
        end
      end
      WAIT2: if (wait_cnt == LAT_LAST) state_n = DONE;
      DONE:  state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (commit) begin
      state_n = IDLE;
      rom_req = 1'b0;
    end
  end

  // Datapath: latch the fetch targets, count ROM latency, fill the shadow
  // registers, and commit them at line start.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit1_q   <= 1'b0;
      hit2_q   <= 1'b0;
      off1_q   <= '0;
      off2_q   <= '0;
      wait_cnt <= '0;
      sh1_row  <= '0;
      sh2_row  <= '0;
      sh1_v    <= 1'b0;
      sh2_v    <= 1'b0;
      P1Row    <= '0;
      P2Row    <= '0;
      P1Valid  <= 1'b0;
      P2Valid  <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      if (trigger) begin
        if (state == IDLE) begin
          hit1_q <= row_hit(next_line, P1Y);
          hit2_q <= row_hit(next_line, P2Y);
          off1_q <= 4'(next_line - P1Y);
          off2_q <= 4'(next_line - P2Y);
          sh1_v  <= 1'b0;
          sh2_v  <= 1'b0;
        end else begin
          Overrun <= 1'b1;
        end
      end

      if ((state == WAIT1 || state == WAIT2) && state_n == state) wait_cnt <= wait_cnt + 4'd1;
      else                                                       wait_cnt <= '0;

      if (!commit && wait_cnt == LAT_LAST) begin
        if (state == WAIT1) begin
          sh1_row <= RomData;
          sh1_v   <= 1'b1;
        end
        if (state == WAIT2) begin
          sh2_row <= RomData;
          sh2_v   <= 1'b1;
        end
      end

      if (commit) begin
        if (state == DONE) begin
          P1Row   <= sh1_row;
          P2Row   <= sh2_row;
          P1Valid <= sh1_v;
          P2Valid <= sh2_v;
        end else begin
          P1Valid <= 1'b0;
          P2Valid <= 1'b0;
          Overrun <= 1'b1;
        end
      end
    end
  end

  assign RomReq    = rom_req;
  assign RomAddr   = rom_addr;
  assign fsm_state = state;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Bench for sprite_row_fetcher. Each scanline is compressed: DrawX steps
// 639, 640..699, 799, 0, 1. A small ROM model answers granted requests one
// cycle later and drives random data at all other times.
module tb_sprite_row_fetcher;

  localparam logic [11:0] P1_BASE = 12'd0;
  localparam logic [11:0] P2_BASE = 12'd16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0, P1Y = '0, P2Y = '0;
  logic        RomReq, RomGnt = 1'b0;
  logic [11:0] RomAddr;
  logic [47:0] RomData = '0;
  logic [47:0] P1Row, P2Row;
  logic        P1Valid, P2Valid, Overrun;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  int extra_reqs = 0;
  logic [11:0] exp_q[$];

  // Expected active state, carried from one line to the next.
  logic        last_v1 = 1'b0, last_v2 = 1'b0, exp_ov = 1'b0;
  logic [47:0] last_r1 = '0, last_r2 = '0;

  // ROM model state.
  logic        pending = 1'b0;
  logic [11:0] pend_addr = '0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0;
  logic [11:0] prev_addr = '0;

  sprite_row_fetcher dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .P1Y(P1Y), .P2Y(P2Y),
    .RomReq(RomReq), .RomGnt(RomGnt), .RomAddr(RomAddr), .RomData(RomData),
    .P1Row(P1Row), .P2Row(P2Row), .P1Valid(P1Valid), .P2Valid(P2Valid),
    .Overrun(Overrun), .fsm_state(fsm_state)
  );

  always #5 Clk = ~Clk;

  function automatic logic [47:0] rom_word(input logic [11:0] a);
    return {a, ~a, a ^ 12'h5A5, a + 12'h111};
  endfunction

  function automatic bit mhit(input int y, input int py, output int off);
    int nl;
    nl  = (y == 524) ? 0 : y + 1;
    off = nl - py;
    return (nl < 480) && (nl >= py) && (nl < py + 16);
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ROM responder and request scoreboard, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Reset) begin
      pending  = 1'b0;
      prev_req = 1'b0;
      prev_gnt = 1'b0;
    end else begin
      if (RomReq) req_cycles++;
      if (prev_req && !prev_gnt && DrawX >= 10'd641 && DrawX <= 10'd799) begin
        check("req_held", 48'(RomReq), 48'd1);
        check("addr_held", 48'(RomAddr), 48'(prev_addr));
      end
      if (RomReq && RomGnt) begin
        if (exp_q.size() > 0) check("rom_addr", 48'(RomAddr), 48'(exp_q.pop_front()));
        else extra_reqs++;
      end
      RomData   = pending ? rom_word(pend_addr) : {16'($urandom), $urandom};
      pending   = RomReq && RomGnt;
      pend_addr = RomAddr;
      prev_req  = RomReq;
      prev_gnt  = RomGnt;
      prev_addr = RomAddr;
    end
  end

  task automatic step(input logic [9:0] x, input logic gnt);
    @(posedge Clk);
    #1;
    DrawX  = x;
    RomGnt = gnt;
  endtask

  // One compressed scanline. gnt_delay < 0 means the grant is never given.
  task automatic run_line(input logic [9:0] y, input logic [9:0] p1, input logic [9:0] p2,
                          input int gnt_delay);
    bit h1, h2, gnt_ok, done;
    int o1, o2, nreq;
    h1 = mhit(y, p1, o1);
    h2 = mhit(y, p2, o2);
    gnt_ok = (gnt_delay >= 0);
    nreq = 0;
    if (gnt_ok && h1) begin exp_q.push_back(P1_BASE + 12'(o1)); nreq++; end
    if (gnt_ok && h2) begin exp_q.push_back(P2_BASE + 12'(o2)); nreq++; end
    @(posedge Clk);
    #1;
    DrawX = 10'd639; DrawY = y; P1Y = p1; P2Y = p2; RomGnt = 1'b0;
    req_cycles = 0;
    extra_reqs = 0;
    for (int i = 0; i < 60; i++) step(10'(640 + i), gnt_ok && (i >= gnt_delay));
    step(10'd799, gnt_ok);
    @(negedge Clk);
    check("hold_v1", 48'(P1Valid), 48'(last_v1));
    check("hold_v2", 48'(P2Valid), 48'(last_v2));
    if (last_v1) check("hold_r1", P1Row, last_r1);
    step(10'd0, gnt_ok);
    step(10'd1, gnt_ok);
    @(negedge Clk);
    done = gnt_ok || (!h1 && !h2);
    if (done) begin
      last_v1 = h1;
      last_v2 = h2;
      if (h1) last_r1 = rom_word(P1_BASE + 12'(o1));
      if (h2) last_r2 = rom_word(P2_BASE + 12'(o2));
    end else begin
      last_v1 = 1'b0;
      last_v2 = 1'b0;
      exp_ov  = 1'b1;
    end
    check("p1_valid", 48'(P1Valid), 48'(last_v1));
    check("p2_valid", 48'(P2Valid), 48'(last_v2));
    if (last_v1) check("p1_row", P1Row, last_r1);
    if (last_v2) check("p2_row", P2Row, last_r2);
    check("overrun", 48'(Overrun), 48'(exp_ov));
    check("req_low_after", 48'(RomReq), 48'd0);
    check("fsm_idle", 48'(fsm_state), 48'd0);
    check("missing_reqs", 48'(exp_q.size()), 48'd0);
    check("extra_reqs", 48'(extra_reqs), 48'd0);
    if (gnt_delay == 0) check("req_cycles", 48'(req_cycles), 48'(nreq));
    exp_q.delete();
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge Clk);
    #1;
    check("rst_req", 48'(RomReq), 48'd0);
    check("rst_v1", 48'(P1Valid), 48'd0);
    check("rst_v2", 48'(P2Valid), 48'd0);
    check("rst_r1", P1Row, 48'd0);
    check("rst_ovr", 48'(Overrun), 48'd0);
    check("rst_fsm", 48'(fsm_state), 48'd0);
    Reset = 1'b0;

    run_line(10'd99,  10'd100, 10'd300, 0);   // P1 row 0 only
    run_line(10'd98,  10'd100, 10'd300, 0);   // line just above sprite
    run_line(10'd214, 10'd200, 10'd200, 0);   // last row of both sprites
    run_line(10'd215, 10'd200, 10'd200, 0);   // one line past both sprites
    run_line(10'd524, 10'd0,   10'd300, 0);   // frame wrap: next line 0
    run_line(10'd479, 10'd470, 10'd475, 0);   // next line not visible
    run_line(10'd205, 10'd200, 10'd200, 40);  // grant stalled 40 cycles
    run_line(10'd99,  10'd100, 10'd300, -1);  // grant never given

    // Reset while waiting for ROM data.
    exp_q.push_back(P1_BASE);
    @(posedge Clk);
    #1;
    DrawX = 10'd639; DrawY = 10'd99; P1Y = 10'd100; P2Y = 10'd300; RomGnt = 1'b1;
    step(10'd640, 1'b1);
    step(10'd641, 1'b1);
    @(negedge Clk);
    check("pre_rst_req", 48'(RomReq), 48'd1);
    step(10'd642, 1'b1);
    check("pre_rst_wait1", 48'(fsm_state), 48'd2);
    #1 Reset = 1'b1;
    #1;
    check("mid_rst_req", 48'(RomReq), 48'd0);
    check("mid_rst_v1", 48'(P1Valid), 48'd0);
    check("mid_rst_ovr", 48'(Overrun), 48'd0);
    check("mid_rst_fsm", 48'(fsm_state), 48'd0);
    check("mid_rst_q", 48'(exp_q.size()), 48'd0);
    exp_q.delete();
    @(posedge Clk);
    #1 Reset = 1'b0;
    last_v1 = 1'b0; last_v2 = 1'b0; exp_ov = 1'b0;
    run_line(10'd99, 10'd100, 10'd300, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
